// File: rtl/sram_access_ctrl.sv
// SRAM access sequencer: accepts one read or write request at a time, walks
// the array through precharge, wordline access and (for reads) sense, then
// holds a response until the consumer takes it.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a request, req_ready high
//   PRE   | one cycle of bitline precharge, wordline off
//   ACC   | wordline on for ACCESS_CYCLES cycles; write drivers on for writes
//   SENSE | one cycle of sense amp enable, column mux sampled at its end
//   DONE  | response valid, all strobes and selects off until rsp_ready
//
// All outputs come straight from flops, so a state's outputs are computed
// alongside the transition into it.
module sram_access_ctrl #(
   parameter int ACCESS_CYCLES = 2,
   parameter int NUM_ROWS      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [7:0]  req_addr,
   input  logic [3:0]  req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [3:0]  rsp_rdata,
   output logic [15:0] row_select,
   output logic [15:0] col_select,
   input  logic [3:0]  mux_data,
   output logic        precharge,
   output logic        wl_en,
   output logic        we_en,
   output logic        sense_en,
   output logic [3:0]  wdata_out
);

   localparam int NUM_WORDS = 16;
   localparam int WORD_SIZE = 4;

   // The counter holds the number of ACC cycles still to go after this one.
   localparam logic [3:0] ACC_RELOAD = 4'(ACCESS_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      ACC,
      SENSE,
      DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   we_q, we_d;
   logic [7:0]             addr_q, addr_d;
   logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
   logic                   req_ready_q, req_ready_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [WORD_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [15:0]            row_select_q, row_select_d;
   logic [NUM_WORDS-1:0]   col_select_q, col_select_d;
   logic                   precharge_q, precharge_d;
   logic                   wl_en_q, wl_en_d;
   logic                   we_en_q, we_en_d;
   logic                   sense_en_q, sense_en_d;
   logic [WORD_SIZE-1:0]   wdata_out_q, wdata_out_d;

   logic [15:0]            row_dec;
   logic [NUM_WORDS-1:0]   col_dec;

   // Decode the latched address; rows beyond the array leave every wordline off.
   always_comb begin
      row_dec = '0;
      if (int'(addr_q[7:4]) < NUM_ROWS) begin
         row_dec[addr_q[7:4]] = 1'b1;
      end
      col_dec = '0;
      col_dec[addr_q[3:0]] = 1'b1;
   end

   // Next state, latched request, counter and the registered outputs.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rsp_rdata_d  = rsp_rdata_q;
      req_ready_d  = 1'b0;
      rsp_valid_d  = 1'b0;
      precharge_d  = 1'b0;
      wl_en_d      = 1'b0;
      we_en_d      = 1'b0;
      sense_en_d   = 1'b0;
      row_select_d = '0;
      col_select_d = '0;
      wdata_out_d  = '0;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               we_d        = req_we;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               state_d     = PRE;
               precharge_d = 1'b1;
            end else begin
               req_ready_d = 1'b1;
            end
         end

         PRE: begin
            state_d      = ACC;
            cnt_d        = ACC_RELOAD;
            wl_en_d      = 1'b1;
            we_en_d      = we_q;
            row_select_d = row_dec;
            col_select_d = col_dec;
            wdata_out_d  = we_q ? wdata_q : '0;
         end

         ACC: begin
            if (cnt_q == 4'd0) begin
               if (we_q) begin
                  state_d     = DONE;
                  rsp_valid_d = 1'b1;
               end else begin
                  state_d      = SENSE;
                  wl_en_d      = 1'b1;
                  sense_en_d   = 1'b1;
                  row_select_d = row_dec;
                  col_select_d = col_dec;
               end
            end else begin
               cnt_d        = cnt_q - 4'd1;
               wl_en_d      = 1'b1;
               we_en_d      = we_q;
               row_select_d = row_dec;
               col_select_d = col_dec;
               wdata_out_d  = we_q ? wdata_q : '0;
            end
         end

         SENSE: begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mux_data;
         end

         DONE: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               req_ready_d = 1'b1;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         row_select_q <= '0;
         col_select_q <= '0;
         precharge_q  <= 1'b0;
         wl_en_q      <= 1'b0;
         we_en_q      <= 1'b0;
         sense_en_q   <= 1'b0;
         wdata_out_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         row_select_q <= row_select_d;
         col_select_q <= col_select_d;
         precharge_q  <= precharge_d;
         wl_en_q      <= wl_en_d;
         we_en_q      <= we_en_d;
         sense_en_q   <= sense_en_d;
         wdata_out_q  <= wdata_out_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign row_select = row_select_q;
   assign col_select = col_select_q;
   assign precharge  = precharge_q;
   assign wl_en      = wl_en_q;
   assign we_en      = we_en_q;
   assign sense_en   = sense_en_q;
   assign wdata_out  = wdata_out_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: a table of accesses checked cycle by cycle,
// a scoreboard for response data, a reset-abort sequence and latency checks
// on ACCESS_CYCLES=1 and 15 builds.
module tb_sram_access_ctrl;

   localparam int TB_AC   = 2;
   localparam int TB_ROWS = 12;

   localparam int K_ZERO  = 0;
   localparam int K_IDLE  = 1;
   localparam int K_PRE   = 2;
   localparam int K_ACC   = 3;
   localparam int K_SENSE = 4;
   localparam int K_DONE  = 5;

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [3:0]  wdata;
      logic [3:0]  mux;
      int          hold;
      logic [15:0] exp_row;
      logic [15:0] exp_col;
      int          exp_lat;
      logic [3:0]  exp_rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid, req_we, rsp_ready;
   logic [7:0]  req_addr;
   logic [3:0]  req_wdata, mux_data;
   logic        req_valid_x, rsp_ready_x;

   logic        req_ready, rsp_valid, precharge, wl_en, we_en, sense_en;
   logic [3:0]  rsp_rdata, wdata_out;
   logic [15:0] row_select, col_select;

   logic        a1_req_ready, a1_rsp_valid, a1_precharge, a1_wl_en, a1_we_en, a1_sense_en;
   logic [3:0]  a1_rsp_rdata, a1_wdata_out;
   logic [15:0] a1_row_select, a1_col_select;

   logic        a15_req_ready, a15_rsp_valid, a15_precharge, a15_wl_en, a15_we_en, a15_sense_en;
   logic [3:0]  a15_rsp_rdata, a15_wdata_out;
   logic [15:0] a15_row_select, a15_col_select;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [3:0]  exp_q[$];
   logic [3:0]  cur_rd;
   vec_t        vecs[8];
   vec_t        rv;

   always #5 clk = ~clk;

   sram_access_ctrl #(.ACCESS_CYCLES(TB_AC), .NUM_ROWS(TB_ROWS)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .row_select(row_select), .col_select(col_select), .mux_data(mux_data),
      .precharge(precharge), .wl_en(wl_en), .we_en(we_en), .sense_en(sense_en),
      .wdata_out(wdata_out)
   );

   sram_access_ctrl #(.ACCESS_CYCLES(1)) u_ac1 (
      .clk(clk), .rst(rst), .req_valid(req_valid_x), .req_ready(a1_req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(a1_rsp_valid), .rsp_ready(rsp_ready_x), .rsp_rdata(a1_rsp_rdata),
      .row_select(a1_row_select), .col_select(a1_col_select), .mux_data(mux_data),
      .precharge(a1_precharge), .wl_en(a1_wl_en), .we_en(a1_we_en), .sense_en(a1_sense_en),
      .wdata_out(a1_wdata_out)
   );

   sram_access_ctrl #(.ACCESS_CYCLES(15)) u_ac15 (
      .clk(clk), .rst(rst), .req_valid(req_valid_x), .req_ready(a15_req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(a15_rsp_valid), .rsp_ready(rsp_ready_x), .rsp_rdata(a15_rsp_rdata),
      .row_select(a15_row_select), .col_select(a15_col_select), .mux_data(mux_data),
      .precharge(a15_precharge), .wl_en(a15_wl_en), .we_en(a15_we_en), .sense_en(a15_sense_en),
      .wdata_out(a15_wdata_out)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [45:0] snap_act();
      return {req_ready, rsp_valid, precharge, wl_en, we_en, sense_en,
              row_select, col_select, wdata_out, rsp_rdata};
   endfunction

   function automatic logic [45:0] snap_exp(input int kind, input vec_t v, input logic [3:0] rd);
      logic rr, rvl, pc, wl, we, se;
      logic [15:0] rs, cs;
      logic [3:0] wo;
      rr = 1'b0; rvl = 1'b0; pc = 1'b0; wl = 1'b0; we = 1'b0; se = 1'b0;
      rs = '0; cs = '0; wo = '0;
      case (kind)
         K_IDLE:  rr = 1'b1;
         K_PRE:   pc = 1'b1;
         K_ACC: begin
            wl = 1'b1; we = v.we; rs = v.exp_row; cs = v.exp_col;
            wo = v.we ? v.wdata : 4'h0;
         end
         K_SENSE: begin
            wl = 1'b1; se = 1'b1; rs = v.exp_row; cs = v.exp_col;
         end
         K_DONE:  rvl = 1'b1;
         default: ;
      endcase
      return {rr, rvl, pc, wl, we, se, rs, cs, wo, rd};
   endfunction

   // One complete access; request inputs are scrambled every cycle after acceptance.
   task automatic run_access(input vec_t v, input int id);
      logic [3:0] rd_before, popped;
      int kind;
      @(negedge clk);
      for (int i = 0; i < 20; i++) if (!req_ready) @(negedge clk);
      check($sformatf("vec%0d ready", id), req_ready, 1);
      if (!req_ready) return;
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
      rsp_ready = 1'b0; mux_data = ~v.mux;
      exp_q.push_back(v.exp_rdata);
      rd_before = cur_rd;
      @(posedge clk);
      for (int n = 0; n <= v.exp_lat; n++) begin
         if (n > 0) @(posedge clk);
         #1;
         req_addr = 8'($urandom); req_wdata = 4'($urandom); req_we = 1'($urandom);
         mux_data = (!v.we && n == v.exp_lat - 1) ? v.mux : ~v.mux;
         @(negedge clk);
         if (n == 0) kind = K_PRE;
         else if (n <= TB_AC) kind = K_ACC;
         else if (n < v.exp_lat) kind = K_SENSE;
         else kind = K_DONE;
         check($sformatf("vec%0d cyc%0d", id, n), snap_act(),
               snap_exp(kind, v, (n == v.exp_lat) ? v.exp_rdata : rd_before));
      end
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clk);
         #1;
         req_addr = 8'($urandom); req_wdata = 4'($urandom); mux_data = 4'($urandom);
         @(negedge clk);
         check($sformatf("vec%0d hold%0d", id, h), snap_act(), snap_exp(K_DONE, v, v.exp_rdata));
      end
      rsp_ready = 1'b1;
      popped = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
      check($sformatf("vec%0d rsp", id), {rsp_valid, rsp_rdata}, {1'b1, popped});
      @(posedge clk);
      #1;
      rsp_ready = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d idle", id), snap_act(), snap_exp(K_IDLE, v, v.exp_rdata));
      cur_rd = v.exp_rdata;
   endtask

   // Structural invariants on all three instances every cycle.
   always @(negedge clk) begin
      if (!rst) begin
         check("invariants",
               {63'd0, $onehot0(row_select) && $onehot0(col_select) && !(precharge && wl_en) &&
                $onehot0(a1_row_select) && $onehot0(a1_col_select) && !(a1_precharge && a1_wl_en) &&
                $onehot0(a15_row_select) && $onehot0(a15_col_select) && !(a15_precharge && a15_wl_en)},
               64'd1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lat1, lat15;
      vecs[0] = '{1'b1, 8'h25, 4'hA, 4'h0, 0, 16'h0004, 16'h0020, 3, 4'h0};
      vecs[1] = '{1'b0, 8'h3F, 4'h0, 4'h5, 0, 16'h0008, 16'h8000, 4, 4'h5};
      vecs[2] = '{1'b0, 8'h25, 4'h0, 4'hC, 5, 16'h0004, 16'h0020, 4, 4'hC};
      vecs[3] = '{1'b1, 8'hD7, 4'h3, 4'h0, 1, 16'h0000, 16'h0080, 3, 4'hC};
      vecs[4] = '{1'b0, 8'hE0, 4'h0, 4'h9, 0, 16'h0000, 16'h0001, 4, 4'h9};
      vecs[5] = '{1'b0, 8'h00, 4'h0, 4'hF, 2, 16'h0001, 16'h0001, 4, 4'hF};
      vecs[6] = '{1'b1, 8'hBF, 4'hF, 4'h0, 0, 16'h0800, 16'h8000, 3, 4'hF};
      vecs[7] = '{1'b0, 8'h1A, 4'h0, 4'h6, 0, 16'h0002, 16'h0400, 4, 4'h6};
      rv      = '{1'b0, 8'h47, 4'h0, 4'h3, 0, 16'h0010, 16'h0080, 4, 4'h3};

      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0; mux_data = '0; req_valid_x = 1'b0; rsp_ready_x = 1'b1;
      cur_rd = 4'h0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset state", snap_act(), snap_exp(K_ZERO, rv, 4'h0));
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_access(vecs[i], i);

      // Reset in the middle of a read: outputs clear at once, no response.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h47; mux_data = 4'h3;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #2 check("rst pre wl_en", wl_en, 1);
      #1 rst = 1'b1;
      #1 check("rst async clear", snap_act(), snap_exp(K_ZERO, rv, 4'h0));
      @(negedge clk);
      check("rst held", snap_act(), snap_exp(K_ZERO, rv, 4'h0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst release ready", snap_act(), snap_exp(K_IDLE, rv, 4'h0));
      cur_rd = 4'h0;
      run_access(rv, 100);

      // Latency of the short and long access builds.
      @(negedge clk);
      check("acx ready", {a1_req_ready, a15_req_ready}, 2'b11);
      req_we = 1'b0; req_addr = 8'h5C; mux_data = 4'h7; req_valid_x = 1'b1;
      @(posedge clk);
      #1 req_valid_x = 1'b0;
      lat1 = -1; lat15 = -1;
      for (int e = 1; e <= 25; e++) begin
         @(posedge clk);
         #1;
         if (a1_rsp_valid && lat1 < 0) lat1 = e;
         if (a15_rsp_valid && lat15 < 0) lat15 = e;
      end
      check("ac1 latency", 64'(lat1), 64'd3);
      check("ac15 latency", 64'(lat15), 64'd17);
      check("acx rdata", {a1_rsp_rdata, a15_rsp_rdata}, 8'h77);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
